// File: rtl/mvm_job_sched.sv
// mvm_job_sched: queues matrix-vector job descriptors and runs them one at a time on mvm
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cmd_*               descriptor push (valid/ready), id and mvm parameters
//   mvm_*               launch pulse and held parameters to mvm; busy/valid back from mvm
//   done_valid/id/err   one-cycle completion report (err = rejected zero-length job)
//   stray_err           sticky flag for result beats seen while no job is running
//   pending, idle       FIFO occupancy and scheduler-quiescent status
module mvm_job_sched #(
  parameter int VEC_ADDRW  = 8,
  parameter int MAT_ADDRW  = 9,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ID_W-1:0]               cmd_id,
  input  logic [VEC_ADDRW-1:0]          cmd_vec_start_addr,
  input  logic [VEC_ADDRW:0]            cmd_vec_num_words,
  input  logic [MAT_ADDRW-1:0]          cmd_mat_start_addr,
  input  logic [MAT_ADDRW:0]            cmd_mat_num_rows,
  output logic                          mvm_start,
  output logic [VEC_ADDRW-1:0]          mvm_vec_start_addr,
  output logic [VEC_ADDRW:0]            mvm_vec_num_words,
  output logic [MAT_ADDRW-1:0]          mvm_mat_start_addr,
  output logic [MAT_ADDRW:0]            mvm_mat_num_rows_per_olane,
  input  logic                          mvm_busy,
  input  logic                          mvm_valid,
  output logic                          done_valid,
  output logic [ID_W-1:0]               done_id,
  output logic                          done_err,
  output logic                          stray_err,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ID_W + 2*VEC_ADDRW + 1 + 2*MAT_ADDRW + 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_e;
  state_e                 state_q;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          wp_q, rp_q;
  logic [PW:0]            occ_q;
  logic [ID_W-1:0]        id_q, h_id;
  logic [VEC_ADDRW-1:0]   va_q, h_va;
  logic [VEC_ADDRW:0]     vw_q, h_vw;
  logic [MAT_ADDRW-1:0]   ma_q, h_ma;
  logic [MAT_ADDRW:0]     mr_q, h_mr, beat_q, beat_nx;
  logic                   err_q, start_q, done_q, stray_q;
  logic                   push, pop;
  assign cmd_ready = occ_q != (PW+1)'(FIFO_DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state_q == IDLE && occ_q != '0 && !mvm_busy;
  assign {h_id, h_va, h_vw, h_ma, h_mr} = mem[rp_q];
  assign beat_nx   = beat_q + (MAT_ADDRW+1)'(1);
  assign mvm_start                  = start_q;
  assign mvm_vec_start_addr         = va_q;
  assign mvm_vec_num_words          = vw_q;
  assign mvm_mat_start_addr         = ma_q;
  assign mvm_mat_num_rows_per_olane = mr_q;
  assign done_valid = done_q;
  assign done_id    = id_q;
  assign done_err   = err_q;
  assign stray_err  = stray_q;
  assign pending    = occ_q;
  assign idle       = state_q == IDLE && occ_q == '0;
  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= {cmd_id, cmd_vec_start_addr, cmd_vec_num_words,
                            cmd_mat_start_addr, cmd_mat_num_rows};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PW'(1);
      if (pop) rp_q <= rp_q + PW'(1);
      occ_q <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      va_q    <= '0;
      vw_q    <= '0;
      ma_q    <= '0;
      mr_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (mvm_valid && state_q != RUN) stray_q <= 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          {id_q, va_q, vw_q, ma_q, mr_q} <= mem[rp_q];
          // Zero-length jobs never reach mvm; they are reported straight away as errors.
          if (h_vw == '0 || h_mr == '0) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          beat_q  <= '0;
          start_q <= 1'b1;
          state_q <= RUN;
        end
        // Completion is counted from result beats; mvm_busy drops before its pipeline drains.
        RUN: if (mvm_valid) begin
          beat_q <= beat_nx;
          if (beat_nx == mr_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
